// File: rtl/fetch_pkg.sv
// Shared opcode constants, FSM state encoding and opcode classes for the fetch sequencer.
package fetch_pkg;

    localparam logic [4:0] OP_JMP  = 5'b11000;
    localparam logic [4:0] OP_BR   = 5'b11001;
    localparam logic [4:0] OP_CALL = 5'b11010;
    localparam logic [4:0] OP_RET  = 5'b11011;
    localparam logic [4:0] OP_HALT = 5'b11111;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StMem,
        StDec,
        StExec,
        StHalt
    } state_e;

    typedef enum logic [2:0] {
        ClsSeq,
        ClsJmp,
        ClsBr,
        ClsCall,
        ClsRet,
        ClsHalt
    } op_class_e;

    // Anything not explicitly a control opcode advances sequentially.
    function automatic op_class_e classify(input logic [4:0] op);
        case (op)
            OP_JMP:  return ClsJmp;
            OP_BR:   return ClsBr;
            OP_CALL: return ClsCall;
            OP_RET:  return ClsRet;
            OP_HALT: return ClsHalt;
            default: return ClsSeq;
        endcase
    endfunction

endpackage

// File: rtl/fetch_ras.sv
// Return-address stack: small LIFO with push/pop, full/empty flags and synchronous active-high reset.
module fetch_ras #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [CW-1:0] count_q;
    logic [IW-1:0] top_idx;
    logic [IW-1:0] push_idx;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign top_idx  = IW'(count_q - CW'(1));
    assign push_idx = IW'(count_q);
    assign top      = mem_q[top_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (push && !full) begin
            count_q <= count_q + CW'(1);
        end else if (pop && !empty) begin
            count_q <= count_q - CW'(1);
        end
    end

    // Storage needs no reset: entries are only read below the count.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[push_idx] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// PC and fetch-control FSM in front of a two-cycle instruction memory.
// Define FETCH_RAS_EN to build the return-address stack and fault detection.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned    AW        = 8,
    parameter logic [AW-1:0]  RESET_PC  = '0,
    parameter int unsigned    RAS_DEPTH = 4
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          start,
    input  logic          stall,
    input  logic [4:0]    opcode,
    input  logic [AW-1:0] Imm,
    input  logic          br_taken,
    input  logic          exec_done,
    output logic [AW-1:0] Address,
    output logic          instRead,
    output logic          inst_valid,
    output logic          halted,
    output logic          fault
);

    state_e        state_q, state_d;
    op_class_e     cls_q, cls_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] pc_inc;

    assign pc_inc = pc_q + AW'(1);

`ifdef FETCH_RAS_EN
    logic          fault_q, fault_d;
    logic          ras_push, ras_pop, ras_full, ras_empty;
    logic [AW-1:0] ras_top;

    fetch_ras #(
        .DEPTH(RAS_DEPTH),
        .W    (AW)
    ) u_ras (
        .clk      (clk),
        .reset    (Reset),
        .push     (ras_push),
        .pop      (ras_pop),
        .push_data(pc_inc),
        .top      (ras_top),
        .full     (ras_full),
        .empty    (ras_empty)
    );

    assign fault = fault_q;
`else
    logic unused_ras_depth;
    assign unused_ras_depth = ^RAS_DEPTH;
    assign fault            = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= StIdle;
            cls_q   <= ClsSeq;
            pc_q    <= RESET_PC;
`ifdef FETCH_RAS_EN
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            pc_q    <= pc_d;
`ifdef FETCH_RAS_EN
            fault_q <= fault_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cls_d    = cls_q;
        pc_d     = pc_q;
        instRead = 1'b0;
`ifdef FETCH_RAS_EN
        fault_d  = fault_q;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (start) state_d = StFetch;
            end
            StFetch: begin
                if (!stall) begin
                    instRead = 1'b1;
                    state_d  = StMem;
                end
            end
            StMem: state_d = StDec;
            StDec: begin
                cls_d   = classify(opcode);
                state_d = StExec;
            end
            StExec: begin
                if (exec_done) begin
                    state_d = StFetch;
                    case (cls_q)
                        ClsJmp:  pc_d = Imm;
                        ClsBr:   pc_d = br_taken ? Imm : pc_inc;
`ifdef FETCH_RAS_EN
                        ClsCall: begin
                            if (ras_full) begin
                                fault_d = 1'b1;
                                state_d = StHalt;
                            end else begin
                                ras_push = 1'b1;
                                pc_d     = Imm;
                            end
                        end
                        ClsRet: begin
                            if (ras_empty) begin
                                fault_d = 1'b1;
                                state_d = StHalt;
                            end else begin
                                ras_pop = 1'b1;
                                pc_d    = ras_top;
                            end
                        end
`else
                        ClsCall: pc_d = Imm;
                        ClsRet:  pc_d = pc_inc;
`endif
                        ClsHalt: state_d = StHalt;
                        default: pc_d = pc_inc;
                    endcase
                end
            end
            StHalt:  state_d = StHalt;
            default: state_d = StIdle;
        endcase
    end

    assign Address    = pc_q;
    assign inst_valid = (state_q == StExec);
    assign halted     = (state_q == StHalt);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer; covers RAS behaviour when FETCH_RAS_EN is set.
module tb_fetch_sequencer;

    localparam logic [4:0] SEQ  = 5'b00000;
    localparam logic [4:0] JMP  = 5'b11000;
    localparam logic [4:0] BR   = 5'b11001;
    localparam logic [4:0] CALL = 5'b11010;
    localparam logic [4:0] RET  = 5'b11011;
    localparam logic [4:0] HALT = 5'b11111;

    logic       clk = 1'b0;
    logic       Reset;
    logic       start;
    logic       stall;
    logic [4:0] opcode;
    logic [7:0] Imm;
    logic       br_taken;
    logic       exec_done;
    logic [7:0] Address;
    logic       instRead;
    logic       inst_valid;
    logic       halted;
    logic       fault;

    int vectors = 0;
    int miscompares = 0;

    fetch_sequencer #(
        .AW       (8),
        .RESET_PC (8'h00),
        .RAS_DEPTH(4)
    ) dut (
        .clk       (clk),
        .Reset     (Reset),
        .start     (start),
        .stall     (stall),
        .opcode    (opcode),
        .Imm       (Imm),
        .br_taken  (br_taken),
        .exec_done (exec_done),
        .Address   (Address),
        .instRead  (instRead),
        .inst_valid(inst_valid),
        .halted    (halted),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1; start = 1'b0; stall = 1'b0; exec_done = 1'b0;
        opcode = SEQ; Imm = 8'h00; br_taken = 1'b0;
        step();
        Reset = 1'b0;
    endtask

    task automatic begin_run();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Runs one full FETCH..EXEC loop with exec_done already high; starts and ends in FETCH.
    task automatic exec_instr(input logic [4:0] op, input logic [7:0] imm, input logic bt);
        opcode = op; Imm = imm; br_taken = bt; exec_done = 1'b1;
        repeat (4) step();
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (Address !== 8'h00) begin miscompares++; $display("FAIL reset_addr: got %h want 00", Address); end
        vectors++; if (instRead !== 1'b0) begin miscompares++; $display("FAIL reset_instread: got %b want 0", instRead); end
        vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted: got %b want 0", halted); end
        vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL reset_fault: got %b want 0", fault); end
        exec_done = 1'b1;
        repeat (3) step();
        vectors++; if (instRead !== 1'b0 || Address !== 8'h00) begin
            miscompares++; $display("FAIL idle_hold: got rd=%b addr=%h want rd=0 addr=00", instRead, Address);
        end
    endtask

    task automatic test_seq();
        logic [7:0] want;
        do_reset();
        opcode = SEQ; exec_done = 1'b1;
        begin_run();
        for (int i = 0; i < 5; i++) begin
            want = 8'(i);
            for (int c = 0; c < 4; c++) begin
                vectors++; if (Address !== want) begin
                    miscompares++; $display("FAIL seq_addr[%0d.%0d]: got %h want %h", i, c, Address, want);
                end
                vectors++; if (instRead !== (c == 0)) begin
                    miscompares++; $display("FAIL seq_instread[%0d.%0d]: got %b want %b", i, c, instRead, c == 0);
                end
                vectors++; if (inst_valid !== (c == 3)) begin
                    miscompares++; $display("FAIL seq_valid[%0d.%0d]: got %b want %b", i, c, inst_valid, c == 3);
                end
                step();
            end
        end
        vectors++; if (Address !== 8'h05) begin miscompares++; $display("FAIL seq_end: got %h want 05", Address); end
    endtask

    task automatic test_jump_wrap();
        exec_instr(JMP, 8'hFF, 1'b0);
        vectors++; if (Address !== 8'hFF) begin miscompares++; $display("FAIL jmp_ff: got %h want ff", Address); end
        exec_instr(SEQ, 8'h00, 1'b0);
        vectors++; if (Address !== 8'h00) begin miscompares++; $display("FAIL wrap: got %h want 00", Address); end
        exec_instr(JMP, 8'h40, 1'b0);
        vectors++; if (Address !== 8'h40) begin miscompares++; $display("FAIL jmp_40: got %h want 40", Address); end
    endtask

    task automatic test_branch();
        exec_instr(JMP, 8'h10, 1'b0);
        exec_instr(BR, 8'h20, 1'b0);
        vectors++; if (Address !== 8'h11) begin miscompares++; $display("FAIL br_not_taken: got %h want 11", Address); end
        exec_instr(JMP, 8'h10, 1'b0);
        exec_instr(BR, 8'h20, 1'b1);
        vectors++; if (Address !== 8'h20) begin miscompares++; $display("FAIL br_taken: got %h want 20", Address); end
    endtask

    task automatic test_stall();
        opcode = SEQ;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            stall = (cyc <= 3);
            exec_done = (cyc == 9);
            #1;
            vectors++; if (instRead !== (cyc == 4)) begin
                miscompares++; $display("FAIL stall_instread[%0d]: got %b want %b", cyc, instRead, cyc == 4);
            end
            vectors++; if (inst_valid !== (cyc >= 7)) begin
                miscompares++; $display("FAIL stall_valid[%0d]: got %b want %b", cyc, inst_valid, cyc >= 7);
            end
            vectors++; if (Address !== 8'h20) begin
                miscompares++; $display("FAIL stall_addr[%0d]: got %h want 20", cyc, Address);
            end
            step();
        end
        stall = 1'b0; exec_done = 1'b0;
        #1;
        vectors++; if (Address !== 8'h21 || instRead !== 1'b1) begin
            miscompares++; $display("FAIL stall_done: got addr=%h rd=%b want addr=21 rd=1", Address, instRead);
        end
    endtask

    task automatic test_reset_mid_exec();
        exec_done = 1'b0;
        repeat (3) step();
        vectors++; if (inst_valid !== 1'b1) begin miscompares++; $display("FAIL mid_exec_valid: got %b want 1", inst_valid); end
        Reset = 1'b1; exec_done = 1'b1; start = 1'b1;
        step();
        Reset = 1'b0; exec_done = 1'b0; start = 1'b0;
        #1;
        vectors++; if (Address !== 8'h00) begin miscompares++; $display("FAIL rst_exec_addr: got %h want 00", Address); end
        vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL rst_exec_valid: got %b want 0", inst_valid); end
        step();
        vectors++; if (instRead !== 1'b0 || Address !== 8'h00) begin
            miscompares++; $display("FAIL rst_exec_idle: got rd=%b addr=%h want rd=0 addr=00", instRead, Address);
        end
    endtask

    task automatic test_call_ret();
        logic [7:0] tgt;
        do_reset();
        begin_run();
        exec_instr(JMP, 8'h05, 1'b0);
        exec_instr(CALL, 8'h30, 1'b0);
        vectors++; if (Address !== 8'h30) begin miscompares++; $display("FAIL call_addr: got %h want 30", Address); end
        exec_instr(RET, 8'h00, 1'b0);
`ifdef FETCH_RAS_EN
        vectors++; if (Address !== 8'h06) begin miscompares++; $display("FAIL ret_addr: got %h want 06", Address); end
`else
        vectors++; if (Address !== 8'h31) begin miscompares++; $display("FAIL ret_seq: got %h want 31", Address); end
`endif
        do_reset();
        begin_run();
        for (int k = 0; k < 4; k++) begin
            tgt = 8'(8'h10 * (k + 1));
            exec_instr(CALL, tgt, 1'b0);
            vectors++; if (Address !== tgt) begin
                miscompares++; $display("FAIL nest_call[%0d]: got %h want %h", k, Address, tgt);
            end
        end
        exec_instr(CALL, 8'h50, 1'b0);
`ifdef FETCH_RAS_EN
        vectors++; if (fault !== 1'b1 || halted !== 1'b1) begin
            miscompares++; $display("FAIL overflow: got fault=%b halted=%b want 1 1", fault, halted);
        end
        vectors++; if (Address !== 8'h40) begin miscompares++; $display("FAIL overflow_pc: got %h want 40", Address); end
        do_reset();
        vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL fault_clear: got %b want 0", fault); end
        begin_run();
        exec_instr(RET, 8'h00, 1'b0);
        vectors++; if (fault !== 1'b1 || halted !== 1'b1 || Address !== 8'h00) begin
            miscompares++; $display("FAIL underflow: got fault=%b halted=%b addr=%h want 1 1 00", fault, halted, Address);
        end
`else
        vectors++; if (fault !== 1'b0 || halted !== 1'b0 || Address !== 8'h50) begin
            miscompares++; $display("FAIL call5_noras: got fault=%b halted=%b addr=%h want 0 0 50", fault, halted, Address);
        end
`endif
    endtask

    task automatic test_halt();
        do_reset();
        begin_run();
        exec_instr(JMP, 8'h77, 1'b0);
        exec_instr(HALT, 8'h12, 1'b0);
        vectors++; if (halted !== 1'b1 || Address !== 8'h77) begin
            miscompares++; $display("FAIL halt_enter: got halted=%b addr=%h want 1 77", halted, Address);
        end
        vectors++; if (instRead !== 1'b0 || inst_valid !== 1'b0) begin
            miscompares++; $display("FAIL halt_outs: got rd=%b valid=%b want 0 0", instRead, inst_valid);
        end
        for (int p = 0; p < 3; p++) begin
            start = 1'b1;
            step();
            start = 1'b0;
            step();
            vectors++; if (halted !== 1'b1 || Address !== 8'h77 || instRead !== 1'b0) begin
                miscompares++; $display("FAIL halt_start[%0d]: got halted=%b addr=%h rd=%b want 1 77 0",
                                        p, halted, Address, instRead);
            end
        end
        do_reset();
        vectors++; if (halted !== 1'b0 || Address !== 8'h00) begin
            miscompares++; $display("FAIL halt_reset: got halted=%b addr=%h want 0 00", halted, Address);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        test_reset();
        test_seq();
        test_jump_wrap();
        test_branch();
        test_stall();
        test_reset_mid_exec();
        test_call_ret();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
